intdiv_sd_sub_pipe: RTL and testbench

// - N-digit carry-free subtractor: SD2 (redundant binary) minuend minus unsigned binary subtrahend.
// - Two-stage valid/ready pipeline. Stage 1 registers the per-digit intermediate sum and transfer.

---
 rtl/intdiv_sd_pkg.sv | 18 +
 rtl/intdiv_sd_digit_sub.sv | 23 ++
 rtl/intdiv_sd_sub_pipe.sv | 132 +++++++++++++
 tb/tb_intdiv_sd_sub_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intdiv_sd_pkg.sv
// Shared definitions for the signed-digit (SD2) divider datapath.
// Holds the digit codes and a digit-to-integer helper.
package intdiv_sd_pkg;

   localparam logic [1:0] SD_NEG1   = 2'b11;
   localparam logic [1:0] SD_ZERO   = 2'b00;
   localparam logic [1:0] SD_POS1_1 = 2'b01;
   localparam logic [1:0] SD_POS1_2 = 2'b10;

   function automatic int sd2_to_int(input logic [1:0] d);
      case (d)
         SD_NEG1: return -1;
         SD_ZERO: return 0;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/intdiv_sd_digit_sub.sv
// One SD2-minus-binary digit cell: m - s = sum - 2*tr.
// Both +1 codes are accepted on the minuend digit.
module intdiv_sd_digit_sub
   import intdiv_sd_pkg::*;
(
   input  logic [1:0] min_i,
   input  logic       sub_i,
   output logic       sum_o,
   output logic       tr_o
);

   logic is_neg;
   logic is_zero;
   logic is_pos;

   assign is_neg  = (min_i == SD_NEG1);
   assign is_zero = (min_i == SD_ZERO);
   assign is_pos  = (min_i == SD_POS1_1) | (min_i == SD_POS1_2);

   assign tr_o  = is_neg | (is_zero & sub_i);
   assign sum_o = ((is_neg | is_pos) & ~sub_i) | (is_zero & sub_i);

endmodule

// File: rtl/intdiv_sd_sub_pipe.sv
// Full-width carry-free SD2 minus binary subtractor, two-stage
// valid/ready pipeline producing SD2 digits, borrow, sign and zero.
module intdiv_sd_sub_pipe
   import intdiv_sd_pkg::*;
#(
   parameter int N     = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   in_min,
   input  logic [N-1:0]     in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_diff,
   output logic             out_borrow,
   output logic             out_neg,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   logic [N-1:0]     sum_w;
   logic [N-1:0]     tr_w;

   logic             s1_vld_q;
   logic [N-1:0]     s1_sum_q;
   logic [N-1:0]     s1_tr_q;
   logic [TAG_W-1:0] s1_tag_q;

   logic             out_vld_q;
   logic [2*N-1:0]   diff_q;
   logic             borrow_q;
   logic             neg_q;
   logic             zero_q;
   logic [TAG_W-1:0] tag_q;

   logic [2*N-1:0]   diff_d;
   logic             borrow_d;
   logic             neg_d;
   logic             zero_d;
   logic [N-1:0]     tr_prev;
   logic             found;
   logic             msb_neg;

   logic             s1_adv;
   logic             s2_adv;

   assign s2_adv   = ~out_vld_q | out_ready;
   assign s1_adv   = ~s1_vld_q | s2_adv;
   assign in_ready = s1_adv;

   for (genvar g = 0; g < N; g++) begin : g_dig
      intdiv_sd_digit_sub u_dig (
         .min_i (in_min[2*g +: 2]),
         .sub_i (in_sub[g]),
         .sum_o (sum_w[g]),
         .tr_o  (tr_w[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_sum_q <= '0;
         s1_tr_q  <= '0;
         s1_tag_q <= '0;
      end else if (s1_adv) begin
         s1_vld_q <= in_valid;
         if (in_valid) begin
            s1_sum_q <= sum_w;
            s1_tr_q  <= tr_w;
            s1_tag_q <= in_tag;
         end
      end
   end

   // Digit i absorbs the transfer coming up from digit i-1.
   assign tr_prev  = {s1_tr_q[N-2:0], 1'b0};
   assign borrow_d = s1_tr_q[N-1];

   always_comb begin
      diff_d  = '0;
      found   = 1'b0;
      msb_neg = 1'b0;
      for (int i = 0; i < N; i++) begin
         case ({s1_sum_q[i], tr_prev[i]})
            2'b10:   diff_d[2*i +: 2] = SD_POS1_1;
            2'b01:   diff_d[2*i +: 2] = SD_NEG1;
            default: diff_d[2*i +: 2] = SD_ZERO;
         endcase
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (!found && diff_d[2*i +: 2] != SD_ZERO) begin
            found   = 1'b1;
            msb_neg = (diff_d[2*i +: 2] == SD_NEG1);
         end
      end
      neg_d  = borrow_d | msb_neg;
      zero_d = ~borrow_d & ~found;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         diff_q    <= '0;
         borrow_q  <= 1'b0;
         neg_q     <= 1'b0;
         zero_q    <= 1'b0;
         tag_q     <= '0;
      end else if (s2_adv) begin
         out_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            tag_q    <= s1_tag_q;
         end
      end
   end

   assign out_valid  = out_vld_q;
   assign out_diff   = diff_q;
   assign out_borrow = borrow_q;
   assign out_neg    = neg_q;
   assign out_zero   = zero_q;
   assign out_tag    = tag_q;

endmodule

// File: tb/tb_intdiv_sd_sub_pipe.sv
// Randomized bench for intdiv_sd_sub_pipe against a value-level model.
// Directed literal cases pin the model; one monitor checks every cycle.
module tb_intdiv_sd_sub_pipe;
   import intdiv_sd_pkg::*;

   localparam int N     = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2*N-1:0]   in_min = '0;
   logic [N-1:0]     in_sub = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [2*N-1:0]   out_diff;
   logic             out_borrow;
   logic             out_neg;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   intdiv_sd_sub_pipe #(.N(N), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_min     (in_min),
      .in_sub     (in_sub),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_diff   (out_diff),
      .out_borrow (out_borrow),
      .out_neg    (out_neg),
      .out_zero   (out_zero),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               val;
      logic [TAG_W-1:0] tag;
      int               acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   delivered = 0;
   int   mode = 0;
   int   k = 0;
   bit   hold_v = 1'b0;
   int   hold_w = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic int sdval(input logic [2*N-1:0] v);
      int r = 0;
      for (int i = 0; i < N; i++) r += sd2_to_int(v[2*i +: 2]) * (1 << i);
      return r;
   endfunction

   function automatic int snap();
      return {out_diff, out_borrow, out_neg, out_zero, out_tag};
   endfunction

   // Downstream ready pattern
   always begin
      @(posedge clk);
      #1;
      k++;
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
         default: out_ready = ($urandom_range(3) != 0);
      endcase
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         hold_v = 1'b0;
      end else begin
         chk("in_ready", int'(in_ready),
             int'(!(q.size() == 2 && out_valid && !out_ready)));
         if (hold_v) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", snap(), hold_w);
         end
         hold_v = 1'b0;
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("stale_word", 1, 0);
            end else begin
               exp_t e;
               int bad;
               e = q[0];
               bad = 0;
               for (int i = 0; i < N; i++)
                  if (out_diff[2*i +: 2] == SD_POS1_2) bad++;
               chk("value", sdval(out_diff) - (int'(out_borrow) << N), e.val);
               chk("neg", int'(out_neg), int'(e.val < 0));
               chk("zero", int'(out_zero), int'(e.val == 0));
               chk("tag", int'(out_tag), int'(e.tag));
               chk("canon", bad, 0);
               chk("lat_min", int'(cyc - e.acc >= 2), 1);
               if (out_ready) begin
                  void'(q.pop_front());
                  delivered++;
               end else begin
                  hold_v = 1'b1;
                  hold_w = snap();
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_t n;
            n.val = sdval(in_min) - int'(in_sub);
            n.tag = in_tag;
            n.acc = cyc;
            q.push_back(n);
         end
      end
   end

   task automatic send(input logic [2*N-1:0] m, input logic [N-1:0] s,
                       input logic [TAG_W-1:0] t);
      int n = 0;
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_min = m;
      in_sub = s;
      in_tag = t;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 1000);
      if (!acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic directed(input string name, input logic [2*N-1:0] m,
                           input logic [N-1:0] s, input logic [TAG_W-1:0] t,
                           input logic [2*N-1:0] ed, input bit eb,
                           input bit en, input bit ez);
      drain();
      send(m, s, t);
      chk({name, "_early"}, int'(out_valid), 0);
      @(posedge clk);
      #1;
      chk({name, "_valid"}, int'(out_valid), 1);
      chk({name, "_diff"}, int'(out_diff), int'(ed));
      chk({name, "_borrow"}, int'(out_borrow), int'(eb));
      chk({name, "_neg"}, int'(out_neg), int'(en));
      chk({name, "_zero"}, int'(out_zero), int'(ez));
      chk({name, "_tag"}, int'(out_tag), int'(t));
      drain();
   endtask

   initial begin
      #5000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      #2;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_outs", snap(), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rel_ready", int'(in_ready), 1);

      // T2..T4 and extra literal cases
      directed("t2", 8'b00_00_00_00, 4'b0001, 4'd5, 8'b00_00_11_01, 0, 1, 0);
      directed("t3", 8'b01_10_01_10, 4'b1111, 4'd6, 8'h00, 0, 0, 1);
      directed("t4", 8'b11_11_11_11, 4'b0000, 4'd7, 8'b00_00_00_01, 1, 1, 0);
      directed("pos15", 8'b01_01_01_01, 4'b0000, 4'd8, 8'b01_01_01_01, 0, 0, 0);
      directed("zz", 8'h00, 4'b0000, 4'd9, 8'h00, 0, 0, 1);

      // T1: reset with two words in flight
      send(8'h55, 4'd3, 4'd1);
      send(8'hAA, 4'd1, 4'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("t1_valid", int'(out_valid), 0);
      chk("t1_outs", snap(), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t1_ready", int'(in_ready), 1);
      repeat (4) @(posedge clk);
      #1;
      chk("t1_no_stale", int'(out_valid), 0);

      // T5: back-pressure ordering
      mode = 1;
      d0 = delivered;
      for (int i = 0; i < 6; i++) send(8'($urandom), 4'($urandom), 4'(i));
      drain();
      chk("t5_count", delivered - d0, 6);

      // T6: random stream
      mode = 2;
      d0 = delivered;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(8'($urandom), 4'($urandom), 4'($urandom));
      end
      mode = 0;
      drain();
      chk("t6_count", delivered - d0, 10000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
